// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/apb_if.sv
// APB bundle between a requester (master) and a completer (slave).
interface apb_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (output psel, penable, pwrite, paddr, input prdata, pready, pslverr);
  modport slave  (input psel, penable, pwrite, paddr, output prdata, pready, pslverr);
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, inst} entries; flush beats push and pop.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 push_entry,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Qualify requests so the FIFO can never under- or overflow.
  always_comb begin
    pop_ok_s  = pop && (count_r != {CW{1'b0}});
    push_ok_s = push && ((count_r != CW'(DEPTH)) || pop_ok_s);
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) mem_r[wr_ptr_r] <= push_entry;
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC register, APB read master, redirect/drop handling and
// the credit check that keeps the entry FIFO from overflowing.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  apb_if.master       imem_apb,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        inst_ready_i
);
  localparam int CW = $clog2(DEPTH+1);

  fetch_state_t  state_r, state_s;
  logic [31:0]   paddr_r, paddr_s;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   next_pc_s;
  logic          drop_r, drop_s;
  logic          complete_s, push_s, pop_s, room_s;
  logic [CW:0]   occ_s;
  logic [CW-1:0] count_s;
  fetch_entry_t  head_s, push_entry_s;
  logic          unused_s;

  // Completion, push qualification, next fetch PC and the credit check.
  always_comb begin
    complete_s = (state_r == ACCESS) && imem_apb.pready;
    push_s     = complete_s && !drop_r && !redirect_valid_i;
    if (redirect_valid_i) begin
      next_pc_s = word_align(redirect_pc_i);
    end else if (push_s) begin
      next_pc_s = paddr_r + 32'd4;
    end else begin
      next_pc_s = fetch_pc_r;
    end
    // Pop is deliberately excluded so decode never reaches the APB outputs.
    if (redirect_valid_i) begin
      occ_s = {(CW+1){1'b0}};
    end else begin
      occ_s = {1'b0, count_s} + {{CW{1'b0}}, push_s};
    end
    room_s       = occ_s < (CW+1)'(DEPTH);
    push_entry_s = '{pc: paddr_r, inst: imem_apb.prdata};
  end

  // APB sequencing and the drop flag for transfers orphaned by a redirect.
  always_comb begin
    state_s = state_r;
    paddr_s = paddr_r;
    drop_s  = drop_r;
    case (state_r)
      IDLE: begin
        if (room_s) begin
          state_s = SETUP;
          paddr_s = next_pc_s;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        state_s = ACCESS;
        drop_s  = drop_r || redirect_valid_i;
      end
      ACCESS: begin
        if (imem_apb.pready) begin
          drop_s = 1'b0;
          if (room_s) begin
            state_s = SETUP;
            paddr_s = next_pc_s;
          end else begin
            state_s = IDLE;
          end
        end else begin
          drop_s = drop_r || redirect_valid_i;
        end
      end
      default: begin
        state_s = IDLE;
        drop_s  = 1'b0;
      end
    endcase
  end

  // State, address, PC and drop registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      paddr_r    <= RESET_PC;
      fetch_pc_r <= RESET_PC;
      drop_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      paddr_r    <= paddr_s;
      fetch_pc_r <= next_pc_s;
      drop_r     <= drop_s;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .pop        (pop_s),
    .flush      (redirect_valid_i),
    .push_entry (push_entry_s),
    .count      (count_s),
    .head       (head_s)
  );

  assign pop_s = inst_valid_o && inst_ready_i;

  // Decode-facing outputs, forced to a NOP at pc 0 when nothing is buffered.
  always_comb begin
    inst_valid_o = (count_s != {CW{1'b0}});
    if (inst_valid_o) begin
      inst_o = head_s.inst;
      pc_o   = head_s.pc;
    end else begin
      inst_o = NOP;
      pc_o   = 32'h0000_0000;
    end
  end

  assign imem_apb.psel    = (state_r != IDLE);
  assign imem_apb.penable = (state_r == ACCESS);
  assign imem_apb.pwrite  = 1'b0;
  assign imem_apb.paddr   = paddr_r;
  assign unused_s         = imem_apb.pslverr;

endmodule
